// File: rtl/load_store_unit_pkg.sv
// Shared encodings and state type for the load/store unit.
package lsu_pkg;

    // Access width encodings (req_width / data_bus_reqw)
    localparam logic [1:0] W_BYTE    = 2'b00;
    localparam logic [1:0] W_HALF    = 2'b01;
    localparam logic [1:0] W_WORD    = 2'b10;
    localparam logic [1:0] W_ILLEGAL = 2'b11;

    // Data bus mode encodings (data_bus_mode)
    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_ISSUE = 2'b01,
        LOAD_WAIT  = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align_check.sv
// Alignment and address-range fault classification for one request.
module lsu_align_check
    import lsu_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR = 32'h3000,
    parameter logic [31:0] SRAM_END_ADDR  = 32'h3FFF,
    parameter logic        CHECK_RANGE    = 1'b1
) (
    input  logic [31:0] addr,
    input  logic [1:0]  width,
    output logic        misaligned,
    output logic        access_fault
);

    // Misalignment wins over a range fault so only one pulse is ever raised
    always_comb begin
        misaligned = 1'b0;
        case (width)
            W_HALF:    misaligned = addr[0];
            W_WORD:    misaligned = |addr[1:0];
            W_ILLEGAL: misaligned = 1'b1;
            default:   misaligned = 1'b0;
        endcase
        access_fault = !misaligned && CHECK_RANGE &&
                       ((addr < SRAM_BASE_ADDR) || (addr > SRAM_END_ADDR));
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: data-bus master between execute stage and data SRAM.
// Stores complete in the accepting cycle; loads take a two-cycle bus read
// with the result returned registered in the following cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR = 32'h3000,
    parameter logic [31:0] SRAM_END_ADDR  = 32'h3FFF,
    parameter logic        CHECK_RANGE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [4:0]  req_rd,
    output logic        stall_lw,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    output logic [1:0]  data_bus_reqw,
    output logic        data_bus_reqs,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        misaligned_fault,
    output logic        access_fault,
    output logic [31:0] fault_addr
);

    lsu_state_t  state;
    logic [31:0] lat_addr;
    logic [1:0]  lat_width;
    logic        lat_signed;
    logic [4:0]  lat_rd;

    logic        chk_misaligned;
    logic        chk_access;
    logic        accept;
    logic        start_store;
    logic        start_load;
    logic        drive_wdata;

    lsu_align_check #(
        .SRAM_BASE_ADDR (SRAM_BASE_ADDR),
        .SRAM_END_ADDR  (SRAM_END_ADDR),
        .CHECK_RANGE    (CHECK_RANGE)
    ) u_align_check (
        .addr         (req_addr),
        .width        (req_width),
        .misaligned   (chk_misaligned),
        .access_fault (chk_access)
    );

    // Gating with reset keeps the bus idle while reset is held, even with a
    // request pending, since bus outputs are driven from the request directly.
    assign req_ready   = (state == IDLE) && reset;
    assign accept      = req_valid && req_ready;
    assign start_store = accept && !chk_misaligned && !chk_access && req_store;
    assign start_load  = accept && !chk_misaligned && !chk_access && !req_store;

    assign data_bus_data = drive_wdata ? req_wdata : 'z;

    // Bus drive: first cycle of any access comes straight from the request,
    // the second load cycle replays the latched fields
    always_comb begin
        data_bus_mode = BUS_IDLE;
        data_bus_addr = '0;
        data_bus_reqw = '0;
        data_bus_reqs = 1'b0;
        stall_lw      = 1'b0;
        drive_wdata   = 1'b0;
        if (start_store) begin
            data_bus_mode = BUS_WRITE;
            data_bus_addr = req_addr;
            data_bus_reqw = req_width;
            drive_wdata   = 1'b1;
        end else if (start_load) begin
            data_bus_mode = BUS_READ;
            data_bus_addr = req_addr;
            data_bus_reqw = req_width;
            data_bus_reqs = req_signed;
            stall_lw      = 1'b1;
        end else if (state == LOAD_ISSUE) begin
            data_bus_mode = BUS_READ;
            data_bus_addr = lat_addr;
            data_bus_reqw = lat_width;
            data_bus_reqs = lat_signed;
        end
    end

    // Sequencer, load capture and fault/result pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            lat_addr         <= '0;
            lat_width        <= '0;
            lat_signed       <= 1'b0;
            lat_rd           <= '0;
            load_valid       <= 1'b0;
            load_data        <= '0;
            load_rd          <= '0;
            misaligned_fault <= 1'b0;
            access_fault     <= 1'b0;
            fault_addr       <= '0;
        end else begin
            load_valid       <= 1'b0;
            misaligned_fault <= 1'b0;
            access_fault     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && chk_misaligned) begin
                        misaligned_fault <= 1'b1;
                        fault_addr       <= req_addr;
                    end else if (accept && chk_access) begin
                        access_fault <= 1'b1;
                        fault_addr   <= req_addr;
                    end else if (start_load) begin
                        lat_addr   <= req_addr;
                        lat_width  <= req_width;
                        lat_signed <= req_signed;
                        lat_rd     <= req_rd;
                        state      <= LOAD_ISSUE;
                    end
                end
                LOAD_ISSUE: begin
                    load_data  <= data_bus_data;
                    load_rd    <= lat_rd;
                    load_valid <= 1'b1;
                    state      <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
